// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter that serialises write/read transactions
// onto a single command-strobe RAM port, with a bounded wait for read data.
module ram_port_arbiter #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [2*ADDR_SIZE-1:0] addr,
  input  logic [2*MEM_WIDTH-1:0] wdata,
  output logic [1:0]             ack,
  output logic [1:0]             err,
  output logic [MEM_WIDTH-1:0]   rdata,
  output logic                   busy,
  output logic                   gnt_id,
  output logic [MEM_WIDTH+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic [MEM_WIDTH-1:0]   ram_dout,
  input  logic                   ram_tx_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, DONE
  } state_t;

  state_t                 state, state_next;
  logic                   last_gnt;
  logic                   we_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [MEM_WIDTH-1:0]   wdata_q;
  logic [CNT_W-1:0]       cnt;
  logic                   err_flag;

  logic                   winner;
  logic                   win_we;
  logic [ADDR_SIZE-1:0]   win_addr;
  logic [MEM_WIDTH-1:0]   win_wdata;

  // Under contention the requester not served last wins; otherwise the sole requester.
  always_comb begin
    winner    = (req == 2'b11) ? ~last_gnt : req[1];
    win_we    = winner ? we[1] : we[0];
    win_addr  = winner ? addr[2*ADDR_SIZE-1:ADDR_SIZE] : addr[ADDR_SIZE-1:0];
    win_wdata = winner ? wdata[2*MEM_WIDTH-1:MEM_WIDTH] : wdata[MEM_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      rdata    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_id   <= winner;
            last_gnt <= winner;
            we_q     <= win_we;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            err_flag <= 1'b0;
          end
        end
        RD_CMD: cnt <= '0;
        RD_WAIT: begin
          // Data arriving on the last permitted cycle beats the timeout.
          if (ram_tx_valid) begin
            rdata    <= ram_dout;
            err_flag <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rdata    <= '0;
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = win_we ? WR_ADDR : RD_ADDR;
      WR_ADDR: state_next = WR_DATA;
      WR_DATA: state_next = DONE;
      RD_ADDR: state_next = RD_CMD;
      RD_CMD:  state_next = RD_WAIT;
      RD_WAIT: if (ram_tx_valid || cnt == CNT_W'(TIMEOUT - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM port and handshake outputs depend only on registered state and latched fields.
  always_comb begin
    ack          = 2'b00;
    err          = 2'b00;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      WR_ADDR: begin
        ram_din      = {2'b00, MEM_WIDTH'(addr_q)};
        ram_rx_valid = 1'b1;
      end
      WR_DATA: begin
        ram_din      = {2'b01, wdata_q};
        ram_rx_valid = 1'b1;
      end
      RD_ADDR: begin
        ram_din      = {2'b10, MEM_WIDTH'(addr_q)};
        ram_rx_valid = 1'b1;
      end
      RD_CMD: begin
        ram_din      = {2'b11, {MEM_WIDTH{1'b0}}};
        ram_rx_valid = 1'b1;
      end
      DONE: begin
        ack = gnt_id ? 2'b10 : 2'b01;
        err = gnt_id ? {err_flag, 1'b0} : {1'b0, err_flag};
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be:
  MEM_WIDTH  8  RAM data width
  ADDR_SIZE  8  RAM address width
  TIMEOUT    4  max cycles spent waiting for ram_tx_valid on a read
REQ-002 Ports SHALL be:
  clk           in   1      clock; all logic on rising edge
  rst_n         in   1      reset; synchronous, active-low
  req           in   2      req[i]: requester i wants a transaction
  we            in   2      we[i]: 1 = write, 0 = read
  addr          in   16     requester i address at [8i+7:8i]
  wdata         in   16     requester i write data at [8i+7:8i]
  ack           out  2      ack[i]: one-cycle completion pulse to requester i
  err           out  2      err[i]: read timeout flag, valid only with ack[i]
  rdata         out  8      read data, valid with ack
  busy          out  1      transaction in progress
  gnt_id        out  1      index of the current or last granted requester
  ram_din       out  10     RAM command word {cmd[1:0], byte[7:0]}
  ram_rx_valid  out  1      RAM command strobe
  ram_dout      in   8      RAM read data
  ram_tx_valid  in   1      RAM read-data valid

Function
REQ-003 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, DONE.
REQ-004 In IDLE with any req bit high, the block SHALL grant one requester and latch its we, addr and wdata. Next state SHALL be WR_ADDR if we=1, else RD_ADDR.
REQ-005 Arbitration SHALL be round-robin. With a single requester, that requester wins. With both requesting, the winner SHALL be the requester not granted last. The last-granted register SHALL update on each grant.
REQ-006 Latched fields SHALL be the only source for the transaction. Changes on we/addr/wdata/req after grant SHALL be ignored.
REQ-007 State sequencing and RAM outputs SHALL be:
  WR_ADDR  ram_din = {2'b00, addr},  ram_rx_valid = 1, then -> WR_DATA
  WR_DATA  ram_din = {2'b01, wdata}, ram_rx_valid = 1, then -> DONE
  RD_ADDR  ram_din = {2'b10, addr},  ram_rx_valid = 1, then -> RD_CMD
  RD_CMD   ram_din = {2'b11, 8'h00}, ram_rx_valid = 1, then -> RD_WAIT
REQ-008 In all other states, ram_rx_valid and ram_din SHALL be 0.
REQ-009 RAM outputs SHALL be decoded from registered state and latched fields only. There SHALL be no combinational path from req/we/addr/wdata to ram_din or ram_rx_valid.
REQ-010 In RD_WAIT, ram_tx_valid=1 SHALL capture ram_dout into rdata and move to DONE with the error flag cleared.
REQ-011 The RD_WAIT counter SHALL clear on entry and increment each cycle. If ram_tx_valid has not been seen after TIMEOUT cycles, the block SHALL go to DONE with the error flag set and rdata=8'h00.
REQ-012 If ram_tx_valid=1 on the final permitted RD_WAIT cycle, it SHALL win: data is captured and no error is flagged.
REQ-013 ram_tx_valid outside RD_WAIT SHALL be ignored.
REQ-014 In DONE:
  ack[gnt_id] = 1 and err[gnt_id] = error flag for exactly one cycle
  the other ack/err bits SHALL be 0
  next state SHALL be IDLE
  req SHALL NOT be sampled in DONE
REQ-015 A req held high into IDLE SHALL start a new transaction. A req dropped mid-transaction SHALL NOT abort it; ack is still pulsed.
REQ-016 rdata SHALL hold its value until the next read completes. Writes SHALL leave rdata unchanged.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Latency from the IDLE grant edge N:
  write: ack at cycle N+3
  read: ack at N+3+k, where k = RD_WAIT cycles spent (1..TIMEOUT); with a 1-cycle RAM, ack at N+4

Reset
REQ-019 On a clk edge with rst_n=0, the block SHALL:
  go to IDLE
  clear ack, err, rdata, busy, gnt_id, ram_din, ram_rx_valid, the counter and the error flag
  set last-granted to 1, so requester 0 wins the first contested grant
REQ-020 Reset mid-transaction SHALL abort with no ack for the aborted transaction.

Verification
REQ-021 Reset: rst_n=0 for 2 cycles with req=2'b11 -> all outputs 0. After release, the first grant is gnt_id=0.
REQ-022 Write: req[0], we[0]=1, addr=8'h3C, wdata=8'hA5 -> ram_din=10'h03C then 10'h1A5 on consecutive cycles with ram_rx_valid=1. ack=2'b01 at N+3, err=0.
REQ-023 Read: req[1], we[1]=0, addr=8'h3C, RAM model returns 8'hA5 one cycle after the 11 command -> ram_din=10'h23C, then 10'h300. rdata=8'hA5 with ack=2'b10 at N+4, err=0.
REQ-024 Contention: req=2'b11 held continuously with mixed we -> gnt_id sequence 0,1,0,1 and acks alternate. No transaction overlaps and ram_rx_valid never fires in DONE or IDLE.
REQ-025 Timeout: RAM model never asserts ram_tx_valid -> ack[i]=1, err[i]=1 and rdata=8'h00 at N+7 (TIMEOUT=4). A variant with ram_tx_valid on the 4th RD_WAIT cycle -> err=0 with data captured.
REQ-026 Reset in RD_WAIT -> next cycle busy=0 and no ack. A subsequent read completes normally.
